// File: rtl/ls_mem_responder.sv
// Load/store memory responder: one outstanding request, fixed-latency response,
// backed by a word-addressed internal RAM with per-byte store enables.
module ls_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_accept;
  logic                  w_wr_en;

  // Addresses below BASE_ADDR fail the first term, so a wrapped offset never lands in range.
  assign w_off      = req_addr - BASE_ADDR;
  assign w_in_range = (req_addr >= BASE_ADDR) && ((w_off >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign w_idx      = w_off[DEPTH_LOG2+1:2];

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_wr_en  = w_accept && req_wen && w_in_range;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) begin
            w_state_next = S_WAIT;
            w_cnt_next   = 4'(LATENCY - 1);
          end else begin
            w_state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = S_RESP;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rdata <= (!req_wen && w_in_range) ? r_mem[w_idx] : 32'd0;
        r_err   <= !w_in_range;
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto a real memory macro; contents start undefined.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && req_wmask[i]) begin
        r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ls_mem_responder.sv
// Directed bench for ls_mem_responder: LATENCY=2 instance for function checks,
// LATENCY=1 and LATENCY=15 instances for timing and back-to-back spacing.
module tb_ls_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic        resp_ready = 1'b0;

  logic        rdy2, vld2, err2;
  logic [31:0] rd2;
  logic        rdy1, vld1, err1;
  logic [31:0] rd1;
  logic        rdy15, vld15, err15;
  logic [31:0] rd15;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ls_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vld2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(err2)
  );

  ls_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vld1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(err1)
  );

  ls_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h8000_0000), .LATENCY(15)) u_l15 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy15),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vld15), .resp_ready(resp_ready), .resp_rdata(rd15), .resp_err(err15)
  );

  // One request on the LATENCY=2 instance with resp_ready high; lat counts falling
  // edges after the accept edge up to the first one showing resp_valid (999 on timeout).
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, output int lat, output logic [31:0] rdata,
                        output logic err);
    int n;
    @(negedge clock);
    n = 0;
    while (!rdy2 && n < 50) begin
      @(negedge clock);
      n++;
    end
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wmask  = mask;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~wdata;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!vld2 && lat < 50);
    if (!vld2) lat = 999;
    rdata = rd2;
    err   = err2;
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", rdy2); end
    checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", vld2); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", rd2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", err2); end
    checks++; if (rdy15 !== 1'b1) begin errors++; $display("FAIL reset_req_ready_l15: got %b want 1", rdy15); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL store_resp: got rdata=%h err=%b want 0/0", rd, er); end
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", er); end
  endtask

  task automatic test_partial_mask();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, lat, rd, er);
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL partial_mask_rdata: got %h want de22be44", rd); end
    do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'h8000_0012, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL zero_mask_rdata: got %h want de22be44", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clock);
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_addr   = 32'h8000_0010;
    resp_ready = 1'b0;
    @(posedge clock);
    #1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h0BAD_0BAD;
    req_wmask = 4'hF;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!vld2 && n < 50);
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vld2 !== 1'b1 || rd2 !== 32'hDE22_BE44 || err2 !== 1'b0 || rdy2 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1/de22be44/0/0",
                 i, vld2, rd2, err2, rdy2);
      end
      @(negedge clock);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL bp_ready_in_handshake: got %b want 0", rdy2); end
    @(negedge clock);
    checks++; if (vld2 !== 1'b0 || rdy2 !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", vld2, rdy2); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, lat, rd, er);
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_low_load: got rdata=%h err=%b want 0/1", rd, er); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_latency: got %0d want 2", lat); end
    do_req(1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_high_store: got rdata=%h err=%b want 0/1", rd, er); end
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL oor_no_write: got rdata=%h err=%b want cafef00d/0", rd, er); end
    do_req(1'b1, 32'h8000_0FFC, 32'h0A0B_0C0D, 4'hF, lat, rd, er);
    do_req(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0A0B_0C0D || er !== 1'b0) begin errors++; $display("FAIL top_word: got rdata=%h err=%b want 0a0b0c0d/0", rd, er); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] rd; logic er;
    @(negedge clock);
    req_valid  = 1'b1;
    req_wen    = 1'b1;
    req_addr   = 32'h8000_0020;
    req_wdata  = 32'h5555_AAAA;
    req_wmask  = 4'hF;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (vld2 !== 1'b0 || rdy2 !== 1'b1) begin errors++; $display("FAIL midop_reset: got valid=%b ready=%b want 0/1", vld2, rdy2); end
    @(negedge clock);
    reset = 1'b0;
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h5555_AAAA || er !== 1'b0) begin errors++; $display("FAIL midop_store_kept: got rdata=%h err=%b want 5555aaaa/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int acc1[8], rise1[8], acc15[8], rise15[8];
    int na1, nr1, na15, nr15;
    logic pv1, pv15;
    for (int i = 0; i < 8; i++) begin
      acc1[i] = -1000; rise1[i] = -1000; acc15[i] = -1000; rise15[i] = -1000;
    end
    na1 = 0; nr1 = 0; na15 = 0; nr15 = 0; pv1 = 1'b0; pv15 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_addr   = 32'h8000_0020;
    resp_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (rdy1 && na1 < 8) begin acc1[na1] = n; na1++; end
      if (vld1 && !pv1 && nr1 < 8) begin rise1[nr1] = n; nr1++; end
      if (rdy15 && na15 < 8) begin acc15[na15] = n; na15++; end
      if (vld15 && !pv15 && nr15 < 8) begin rise15[nr15] = n; nr15++; end
      pv1 = vld1;
      pv15 = vld15;
      @(negedge clock);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rise1[i] - acc1[i] !== 1) begin errors++; $display("FAIL l1_latency[%0d]: got %0d want 1", i, rise1[i] - acc1[i]); end
      checks++; if (acc1[i+1] - acc1[i] !== 2) begin errors++; $display("FAIL l1_spacing[%0d]: got %0d want 2", i, acc1[i+1] - acc1[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rise15[i] - acc15[i] !== 15) begin errors++; $display("FAIL l15_latency[%0d]: got %0d want 15", i, rise15[i] - acc15[i]); end
      checks++; if (acc15[i+1] - acc15[i] !== 16) begin errors++; $display("FAIL l15_spacing[%0d]: got %0d want 16", i, acc15[i+1] - acc15[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_mask();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_op();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ls_mem_responder.md
Name: ls_mem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one load or store request at a time and returns a response after a fixed, configurable latency.
- Backed by an internal word-addressed RAM instead of a DPI call, so simulation and synthesis produce identical, cycle-accurate memory timing.
- Sits between the LSU request channel and the memory map, and replaces direct pmem access for the data side.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
- LATENCY, 2, cycles from the request-accept edge to resp_valid rising; legal range 1..15.

Ports:
- clock  input  1  single clock domain; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wen  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  store data, byte lanes aligned to the word.
- req_wmask  input  4  byte enables for a store; bit i enables byte lane i.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2).

Behaviour:
- Reset, asserted asynchronously: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- RAM contents are not reset.
- A request is accepted on a rising edge where req_valid && req_ready.
- FSM states:
  - IDLE: req_ready=1. On accept, go to WAIT if LATENCY>1, otherwise go to RESP.
  - WAIT: req_ready=0. The counter loads LATENCY-1 on accept and decrements each cycle; go to RESP when the counter reaches 1.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1. On the resp_ready edge return to IDLE, with resp_valid=0 next cycle.
- Net timing: resp_valid rises exactly LATENCY cycles after the accept edge. Minimum request-to-request spacing is LATENCY+1 cycles with resp_ready tied high.
- No back-to-back overlap: req_ready stays low in the same cycle the response handshakes. req_ready rises the following cycle.
- Index = (req_addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits after the range check.
- Store, in range: on the accept edge, byte lane i of the word is written with req_wdata[8i+7:8i] iff req_wmask[i]. Lanes with mask 0 are unchanged. wmask=0 is legal and writes nothing. Response has resp_rdata=0, resp_err=0.
- Load, in range: the word is read on the accept edge and captured into the response register. A later store cannot alter it, since only one request is outstanding. resp_err=0.
- Out of range (load or store): no RAM write, resp_rdata=0, resp_err=1, same latency as in-range requests.
- Request fields are only sampled on the accept edge. Changes to them while req_ready=0 are ignored.
- resp_ready asserted while resp_valid=0 has no effect.
- Reset asserted during WAIT or RESP: the outstanding response is dropped and the FSM returns to IDLE. A store accepted before reset remains committed.
- Address wrap: an address below BASE_ADDR flags an error. The subtraction is not allowed to wrap into range.

Test Plan:
1. LATENCY=2. Store addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0xF, then load the same address with resp_ready=1 → load resp_valid 2 cycles after accept, resp_rdata=0xDEAD_BEEF, resp_err=0.
2. Partial mask. After test 1, store wdata 0x1122_3344 with wmask 0b0101, then load → resp_rdata=0xDE22_BE44.
3. Backpressure. Load with resp_ready held 0 for 5 cycles after resp_valid → resp_valid, resp_rdata and resp_err stay constant and req_ready=0 throughout. Raise resp_ready → resp_valid=0 and req_ready=1 on the next cycle.
4. Out of range. Load 0x7FFF_FFFC and store 0x8000_1000 (DEPTH_LOG2=10) → both give resp_err=1, resp_rdata=0. A subsequent load of 0x8000_0000 shows unchanged contents.
5. LATENCY=1 and LATENCY=15 builds. Back-to-back loads with resp_ready=1 → resp_valid exactly 1 or 15 cycles after each accept. Accept spacing is 2 or 16 cycles.
6. Reset mid-op. Store accepted, reset pulsed (asynchronously, mid-cycle) during WAIT → resp_valid=0 and req_ready=1 immediately. A later load returns the stored data.
